ps2_mouse_tracker: RTL and testbench



---
 rtl/ps2_mouse_tracker_pkg.sv | 47 ++++
 rtl/ps2_mouse_tracker_byte_rx.sv | 123 ++++++++++++
 rtl/ps2_mouse_tracker.sv | 126 ++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared constants, packet field positions and helpers for the PS/2 mouse tracker.
// Pulled in by both the byte receiver and the packet integrator.
package ps2_mouse_tracker_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 10;

  localparam int PKT_L       = 0;
  localparam int PKT_R       = 1;
  localparam int PKT_ALWAYS1 = 3;
  localparam int PKT_XS      = 4;
  localparam int PKT_YS      = 5;
  localparam int PKT_XO      = 6;
  localparam int PKT_YO      = 7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_e;

  typedef struct packed {
    logic yOvf;
    logic xOvf;
    logic ySign;
    logic xSign;
    logic right;
    logic left;
  } pktHdr_t;

  // Saturates a signed 12-bit candidate position into 0..maxV.
  function automatic logic [POS_W-1:0] clampAxis(input logic signed [11:0] v,
                                                 input logic [POS_W-1:0]   maxV);
    logic [POS_W-1:0] result;
    if (v < 12'sd0) begin
      result = '0;
    end else if (v > $signed({2'b00, maxV})) begin
      result = maxV;
    end else begin
      result = v[POS_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_mouse_tracker_byte_rx.sv
// PS/2 device-to-host byte receiver: line synchronisers, falling-edge detect,
// start/data/parity/stop framing and the inter-edge watchdog.
module ps2_byte_rx
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_in,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       armed_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clkMeta_q, clkSync_q, clkPrev_q;
  logic          dataMeta_q, dataSync_q;
  rxState_e      state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          byteValid_q, byteValid_d;
  logic          err_q, err_d;
  logic          fall;
  logic          timeoutHit;

  // Synchronisers free-run so no artificial edge appears when reset lifts.
  always_ff @(posedge clk_in) begin
    clkMeta_q  <= ps2_clk_i;
    clkSync_q  <= clkMeta_q;
    dataMeta_q <= ps2_data_i;
    dataSync_q <= dataMeta_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_i) begin
      clkPrev_q   <= 1'b0;
      state_q     <= RX_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      cnt_q       <= '0;
      byteValid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clkPrev_q   <= clkSync_q;
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      cnt_q       <= cnt_d;
      byteValid_q <= byteValid_d;
      err_q       <= err_d;
    end
  end

  assign fall       = clkPrev_q & ~clkSync_q;
  assign timeoutHit = ~fall && (cnt_q == TW'(TIMEOUT_CYC)) && armed_i;

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    byteValid_d = 1'b0;
    err_d       = 1'b0;

    if (fall || timeoutHit) begin
      cnt_d = '0;
    end else if (cnt_q == TW'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (timeoutHit) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dataSync_q) begin
            state_d  = RX_DATA;
            bitCnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d  = {dataSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          parity_d = dataSync_q;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (dataSync_q && (^{shift_q, parity_q})) begin
            byteValid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byteValid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse front end: assembles 3-byte stream packets and integrates the
// deltas into a pointer position clamped to the visible screen.
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int X_MAX       = SCREEN_W - 1,
  parameter int Y_MAX       = SCREEN_H - 1,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk_in,
  input  logic             BTN_SOUTH,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [POS_W-1:0] mouse_pos_x,
  output logic [POS_W-1:0] mouse_pos_y,
  output logic [1:0]       mouse_click,
  output logic             packet_strobe,
  output logic             frame_err
);

  logic [7:0]       rxByte;
  logic             rxValid;
  logic             rxErr;
  logic             rxBusy;
  logic             armTimeout;

  logic [1:0]       idx_q, idx_d;
  pktHdr_t          hdr_q, hdr_d;
  logic [7:0]       dxLo_q, dxLo_d;
  logic [POS_W-1:0] posX_q, posX_d;
  logic [POS_W-1:0] posY_q, posY_d;
  logic [1:0]       click_q, click_d;
  logic             strobe_q, strobe_d;

  logic signed [8:0]  dx9, dy9;
  logic signed [11:0] nx, ny;

  // A quiet line is only an error while a frame or a packet is in flight.
  assign armTimeout = rxBusy || (idx_q != 2'd0);

  ps2_byte_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_in      (clk_in),
    .reset_i     (BTN_SOUTH),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .armed_i     (armTimeout),
    .byte_o      (rxByte),
    .byte_valid_o(rxValid),
    .err_o       (rxErr),
    .busy_o      (rxBusy)
  );

  always_ff @(posedge clk_in) begin
    if (BTN_SOUTH) begin
      idx_q    <= 2'd0;
      hdr_q    <= '0;
      dxLo_q   <= '0;
      posX_q   <= POS_W'(X_INIT);
      posY_q   <= POS_W'(Y_INIT);
      click_q  <= 2'b00;
      strobe_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      dxLo_q   <= dxLo_d;
      posX_q   <= posX_d;
      posY_q   <= posY_d;
      click_q  <= click_d;
      strobe_q <= strobe_d;
    end
  end

  // Byte 2 is applied straight from the receiver so outputs move one cycle later.
  assign dx9 = hdr_q.xOvf ? 9'sd0 : $signed({hdr_q.xSign, dxLo_q});
  assign dy9 = hdr_q.yOvf ? 9'sd0 : $signed({hdr_q.ySign, rxByte});
  assign nx  = $signed({2'b00, posX_q}) + {{3{dx9[8]}}, dx9};
  assign ny  = $signed({2'b00, posY_q}) - {{3{dy9[8]}}, dy9};

  always_comb begin
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    dxLo_d   = dxLo_q;
    posX_d   = posX_q;
    posY_d   = posY_q;
    click_d  = click_q;
    strobe_d = 1'b0;

    if (rxErr) begin
      idx_d = 2'd0;
    end else if (rxValid) begin
      case (idx_q)
        2'd0: begin
          if (rxByte[PKT_ALWAYS1]) begin
            hdr_d = '{yOvf:  rxByte[PKT_YO], xOvf:  rxByte[PKT_XO],
                      ySign: rxByte[PKT_YS], xSign: rxByte[PKT_XS],
                      right: rxByte[PKT_R],  left:  rxByte[PKT_L]};
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          dxLo_d = rxByte;
          idx_d  = 2'd2;
        end
        2'd2: begin
          idx_d    = 2'd0;
          posX_d   = clampAxis(nx, POS_W'(X_MAX));
          posY_d   = clampAxis(ny, POS_W'(Y_MAX));
          click_d  = {hdr_q.right, hdr_q.left};
          strobe_d = 1'b1;
        end
        default: idx_d = 2'd0;
      endcase
    end
  end

  assign mouse_pos_x   = posX_q;
  assign mouse_pos_y   = posY_q;
  assign mouse_click   = click_q;
  assign packet_strobe = strobe_q;
  assign frame_err     = rxErr;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: table vectors, hand-written
// corner sequences and randomized packets against a packet-level model.
module tb_ps2_mouse_tracker;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;
  localparam int GAP     = 40;

  logic       clk_in = 1'b0;
  logic       BTN_SOUTH = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouse_pos_x, mouse_pos_y;
  logic [1:0] mouse_click;
  logic       packet_strobe, frame_err;

  int testsRun = 0;
  int testsFailed = 0;
  int strobeCnt = 0;
  int errCnt = 0;

  int         mX, mY, mStrobes, mErrs;
  logic [1:0] mClick;
  logic [7:0] mPkt[$];

  typedef struct {
    bit         doReset;
    logic [7:0] b0, b1, b2;
    int         expX, expY;
    logic [1:0] expClick;
  } vec_t;

  vec_t vecs[8];

  ps2_mouse_tracker #(
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk_in       (clk_in),
    .BTN_SOUTH    (BTN_SOUTH),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .mouse_pos_x  (mouse_pos_x),
    .mouse_pos_y  (mouse_pos_y),
    .mouse_click  (mouse_click),
    .packet_strobe(packet_strobe),
    .frame_err    (frame_err)
  );

  always #10 clk_in = ~clk_in;

  // Pulse counters: a stuck strobe or error line counts more than once.
  always @(negedge clk_in) begin
    if (packet_strobe) strobeCnt++;
    if (frame_err) errCnt++;
  end

  function automatic int clampI(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic void modelReset();
    mX = 320; mY = 240; mClick = 2'b00;
    mPkt.delete();
  endfunction

  function automatic void modelByte(input logic [7:0] b, input bit good);
    int dx, dy;
    logic [7:0] h;
    if (!good) begin
      mErrs++;
      mPkt.delete();
      return;
    end
    if (mPkt.size() == 0 && !b[3]) return;
    mPkt.push_back(b);
    if (mPkt.size() == 3) begin
      h  = mPkt[0];
      dx = h[6] ? 0 : (h[4] ? int'(mPkt[1]) - 256 : int'(mPkt[1]));
      dy = h[7] ? 0 : (h[5] ? int'(mPkt[2]) - 256 : int'(mPkt[2]));
      mX = clampI(mX + dx, 639);
      mY = clampI(mY - dy, 479);
      mClick = {h[1], h[0]};
      mStrobes++;
      mPkt.delete();
    end
  endfunction

  function automatic void modelTimeout();
    if (mPkt.size() != 0) begin
      mErrs++;
      mPkt.delete();
    end
  endfunction

  task automatic compareInt(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic bitVal);
    ps2_data = bitVal;
    repeat (HALF) @(negedge clk_in);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_in);
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badParity, input bit badStop);
    logic [10:0] fr;
    fr = {~badStop, (~^b) ^ badParity, b, 1'b0};
    for (int i = 0; i < 11; i++) pulse(fr[i]);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk_in);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit badStop);
    sendFrame(b, badParity, badStop);
    modelByte(b, !(badParity || badStop));
  endtask

  task automatic doReset();
    @(negedge clk_in);
    BTN_SOUTH = 1'b1;
    repeat (2) @(negedge clk_in);
    BTN_SOUTH = 1'b0;
    modelReset();
    waitCycles(2);
  endtask

  task automatic checkOutput(input string tag);
    #1;
    compareInt({tag, ".x"}, int'(mouse_pos_x), mX);
    compareInt({tag, ".y"}, int'(mouse_pos_y), mY);
    compareInt({tag, ".click"}, int'(mouse_click), int'(mClick));
    compareInt({tag, ".strobes"}, strobeCnt, mStrobes);
    compareInt({tag, ".errs"}, errCnt, mErrs);
  endtask

  initial begin
    logic [7:0] rb;
    bit         bad;

    vecs[0] = '{1'b1, 8'h09, 8'h0A, 8'h05, 330, 235, 2'b01};
    vecs[1] = '{1'b1, 8'h3A, 8'h00, 8'h00,  64, 479, 2'b10};
    vecs[2] = '{1'b0, 8'h3A, 8'h00, 8'h00,   0, 479, 2'b10};
    vecs[3] = '{1'b0, 8'h48, 8'h7F, 8'h10,   0, 463, 2'b00};
    vecs[4] = '{1'b0, 8'h08, 8'hFF, 8'h00, 255, 463, 2'b00};
    vecs[5] = '{1'b0, 8'h18, 8'h01, 8'h00,   0, 463, 2'b00};
    vecs[6] = '{1'b0, 8'h28, 8'h00, 8'h01,   0, 479, 2'b00};
    vecs[7] = '{1'b0, 8'h0B, 8'h7F, 8'h80, 127, 351, 2'b11};

    mStrobes = 0;
    mErrs = 0;
    modelReset();

    doReset();
    compareInt("reset.x", int'(mouse_pos_x), 320);
    compareInt("reset.y", int'(mouse_pos_y), 240);
    compareInt("reset.click", int'(mouse_click), 0);
    compareInt("reset.strobe", int'(packet_strobe), 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].doReset) doReset();
      applyStimulus(vecs[i].b0, 0, 0);
      applyStimulus(vecs[i].b1, 0, 0);
      applyStimulus(vecs[i].b2, 0, 0);
      compareInt($sformatf("vec%0d.x", i), int'(mouse_pos_x), vecs[i].expX);
      compareInt($sformatf("vec%0d.y", i), int'(mouse_pos_y), vecs[i].expY);
      compareInt($sformatf("vec%0d.click", i), int'(mouse_click), int'(vecs[i].expClick));
      checkOutput($sformatf("vec%0d", i));
    end

    // Parity error on byte 1 discards the packet, then a clean packet applies.
    applyStimulus(8'h09, 0, 0);
    applyStimulus(8'h0A, 1, 0);
    checkOutput("parity");
    applyStimulus(8'h09, 0, 0);
    applyStimulus(8'h0A, 0, 0);
    applyStimulus(8'h05, 0, 0);
    checkOutput("afterParity");

    // Stop-bit error on byte 2.
    applyStimulus(8'h0A, 0, 0);
    applyStimulus(8'h10, 0, 0);
    applyStimulus(8'h20, 0, 1);
    checkOutput("stopErr");

    // Timeout after a lone header byte, then a non-header packet, then a good one.
    applyStimulus(8'h09, 0, 0);
    waitCycles(TIMEOUT + 100);
    modelTimeout();
    checkOutput("timeout");
    applyStimulus(8'h00, 0, 0);
    applyStimulus(8'h00, 0, 0);
    applyStimulus(8'h00, 0, 0);
    waitCycles(TIMEOUT + 100);
    checkOutput("resyncDrop");
    applyStimulus(8'h19, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h20, 0, 0);
    checkOutput("resyncGood");

    // Reset half-way through a frame; trailing edges with data high are ignored.
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    doReset();
    for (int i = 0; i < 7; i++) pulse(1'b1);
    waitCycles(TIMEOUT + 50);
    checkOutput("midReset");
    applyStimulus(8'h08, 0, 0);
    applyStimulus(8'h05, 0, 0);
    applyStimulus(8'h03, 0, 0);
    checkOutput("afterMidReset");

    for (int p = 0; p < 40; p++) begin
      for (int j = 0; j < 3; j++) begin
        rb = 8'($urandom);
        if (j == 0 && ($urandom % 8) != 0) rb[3] = 1'b1;
        bad = (($urandom % 12) == 0);
        applyStimulus(rb, bad, 0);
      end
      checkOutput($sformatf("rand%0d", p));
    end
    waitCycles(TIMEOUT + 100);
    modelTimeout();
    checkOutput("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
